// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: round-robin arbiter for two requesters moving a byte between NREG registers.
// Optional macro BUS_GUARD_EN adds a one-cycle TURN state after every transfer.
//
// state | meaning
// IDLE  | arbitrate and accept one command
// XFER  | drive enables for the registered command, pulse done
// TURN  | bus turnaround, no enables (BUS_GUARD_EN only)
module reg_xfer_ctrl #(
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SELW-1:0] req0_src,
    input  logic [SELW-1:0] req0_dst,
    input  logic            req0_bus,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SELW-1:0] req1_src,
    input  logic [SELW-1:0] req1_dst,
    input  logic            req1_bus,
    output logic [NREG-1:0] rdata_en,
    output logic [NREG-1:0] wdata_en,
    output logic [NREG-1:0] raddr_en,
    output logic [NREG-1:0] waddr_en,
    output logic            busy,
    output logic            done,
    output logic            grant_id
);

`ifdef BUS_GUARD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TURN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [SELW-1:0] cmd_src;
    logic [SELW-1:0] cmd_dst;
    logic            cmd_bus;
    logic            pick1;
    logic            accept;
    logic [NREG-1:0] src_hot;
    logic [NREG-1:0] dst_hot;
    logic            cmd_ok;

    // With no valid requester the ready still points at the one that would win a tie.
    assign pick1      = (req1_valid && !req0_valid) || ((req1_valid == req0_valid) && !grant_id);
    assign req0_ready = rst_n && (state == IDLE) && !pick1;
    assign req1_ready = rst_n && (state == IDLE) && pick1;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= 1'b1;
            cmd_src  <= '0;
            cmd_dst  <= '0;
            cmd_bus  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant_id <= pick1;
                cmd_src  <= pick1 ? req1_src : req0_src;
                cmd_dst  <= pick1 ? req1_dst : req0_dst;
                cmd_bus  <= pick1 ? req1_bus : req0_bus;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = XFER;
`ifdef BUS_GUARD_EN
            XFER:    state_nxt = TURN;
            TURN:    state_nxt = IDLE;
`else
            XFER:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range indices decode to an all-zero vector, which also suppresses the transfer.
    always_comb begin
        src_hot = '0;
        dst_hot = '0;
        for (int i = 0; i < NREG; i++) begin
            src_hot[i] = (cmd_src == SELW'(i));
            dst_hot[i] = (cmd_dst == SELW'(i));
        end
    end

    assign cmd_ok = (|src_hot) && (|dst_hot) && (cmd_src != cmd_dst);

    always_comb begin
        rdata_en = '0;
        wdata_en = '0;
        raddr_en = '0;
        waddr_en = '0;
        done     = 1'b0;
        busy     = (state != IDLE);
        if (state == XFER) begin
            done = 1'b1;
            if (cmd_ok) begin
                if (cmd_bus) begin
                    raddr_en = src_hot;
                    waddr_en = dst_hot;
                end else begin
                    rdata_en = src_hot;
                    wdata_en = dst_hot;
                end
            end
        end
    end

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 Parameter NREG, default 8: number of attached 8-bit registers; valid range 2..8.
REQ-002 Parameter SELW, default 3: register-select width; SHALL satisfy 2**SELW >= NREG.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 req0_valid  input  1  requester 0 (fetch) has a transfer command.
REQ-006 req0_ready  output  1  requester 0 command accepted this cycle.
REQ-007 req0_src, req0_dst  input  SELW each  source and destination register index.
REQ-008 req0_bus  input  1  bus select: 0 = data bus, 1 = address bus.
REQ-009 req1_valid, req1_ready, req1_src, req1_dst, req1_bus  same as REQ-005..008  requester 1 (execute).
REQ-010 rdata_en, wdata_en  output  NREG each  one-hot data-bus read/write enables, bit i to register i.
REQ-011 raddr_en, waddr_en  output  NREG each  one-hot address-bus read/write enables.
REQ-012 busy  output  1  high while state is not IDLE.
REQ-013 done  output  1  one-cycle pulse in the cycle a transfer executes.
REQ-014 grant_id  output  1  requester that owns the current or most recent transfer.

Function
REQ-015 FSM states: IDLE, XFER, and TURN when BUS_GUARD_EN is defined.
REQ-016 In IDLE, exactly one reqN_ready SHALL be high; a command is accepted when reqN_valid && reqN_ready.
REQ-017 Arbitration is round-robin: if only one requester is valid it gets ready; if both are valid, the requester not named by grant_id gets ready.
REQ-018 reqN_ready SHALL depend only on state, grant_id and the two valid inputs.
REQ-019 On accept, src, dst, bus and requester id SHALL be registered, grant_id updated, and the FSM SHALL move to XFER.
REQ-020 In XFER, for bus=0: rdata_en[src]=1 and wdata_en[dst]=1; for bus=1: raddr_en[src]=1 and waddr_en[dst]=1; all other enable bits 0.
REQ-021 At most one read-enable bit per bus SHALL be high in any cycle; no enables outside XFER.
REQ-022 Enables SHALL be decoded from registered state and command only, never from request inputs.
REQ-023 If src==dst, XFER SHALL assert no enables; done still pulses.
REQ-024 If src or dst >= NREG, XFER SHALL assert no enables; done still pulses.
REQ-025 done=1 only in XFER; XFER lasts exactly one cycle.
REQ-026 After XFER, the FSM SHALL go to IDLE; the next accept is possible the cycle after; throughput is 1 transfer per 2 cycles.
REQ-027 Latency from accept edge to the destination register latching is 1 cycle: the register captures at the posedge ending XFER.
REQ-028 A requester keeping valid high after acceptance is treated as a new command.

Reset
REQ-029 When rst_n=0 at posedge clk: state=IDLE, grant_id=1 (so requester 0 wins the first tie), registered command=0.
REQ-030 During and after reset: all enables=0, done=0, busy=0.
REQ-031 Reset asserted during XFER SHALL abort it; enables are low from the next cycle, with no retry.
REQ-032 ready SHALL be 0 while rst_n=0.

Configuration
REQ-033 Macro BUS_GUARD_EN:
- Defined: XFER goes to TURN for one cycle (no enables, busy=1, ready=0), then to IDLE; throughput is 1 transfer per 3 cycles.
- Undefined: TURN does not exist and REQ-026 applies.

Verification
REQ-034 Reset, then req0 {src=2,dst=5,bus=0} only -> ready0=1 in IDLE; next cycle rdata_en=8'h04, wdata_en=8'h20, done=1, grant_id=0.
REQ-035 Both valid continuously, req0 {1->3,bus 1}, req1 {4->6,bus 0} -> grants alternate 0,1,0,1; XFER cycles alternate raddr_en=8'h02/waddr_en=8'h08 and rdata_en=8'h10/wdata_en=8'h40.
REQ-036 req1 {src=3,dst=3,bus=0} -> done=1 with all four enable vectors 0; also NREG=6 with dst=7 -> no enables, done=1.
REQ-037 rst_n driven low in the XFER cycle -> next cycle all enables 0, busy=0, grant_id=1; req0 is granted first afterwards.
REQ-038 Back-to-back single requester -> done every 2nd cycle without BUS_GUARD_EN, every 3rd cycle with it; no enables during TURN.
REQ-039 Random stress, 10k cycles -> assertion holds: at most one bit set in rdata_en and in raddr_en, and no enables outside XFER.
